// File: rtl/image_row_loader.sv
// Frame loader: packs a raster pixel stream into rows and writes each row
// to the image RAM, then flags the frame as resident for the convolver.
module image_row_loader #(
    parameter int PIX_W   = 8,
    parameter int ROW_PIX = 130,
    parameter int ROWS    = 130
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     pix_valid,
    input  logic [PIX_W-1:0]         pix_data,
    output logic                     pix_ready,
    output logic                     ram_we,
    output logic [7:0]               ram_addr,
    output logic [PIX_W*ROW_PIX-1:0] ram_wdata,
    output logic                     conv_run,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int RW = PIX_W * ROW_PIX;
    localparam logic [7:0] LAST_PIX = 8'(ROW_PIX - 1);
    localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      pix_cnt_q, pix_cnt_d;
    logic [7:0]      row_q, row_d;
    logic [7:0]      addr_q, addr_d;
    logic [RW-1:0]   row_buf_q, row_buf_d;
    logic            conv_q, conv_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            pix_cnt_q <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            row_buf_q <= '0;
            conv_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            row_buf_q <= row_buf_d;
            conv_q    <= conv_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        row_d      = row_q;
        addr_d     = addr_q;
        row_buf_d  = row_buf_q;
        conv_d     = conv_q;
        pix_ready  = 1'b0;
        ram_we     = 1'b0;
        frame_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    pix_cnt_d = '0;
                    row_d     = '0;
                    conv_d    = 1'b0;
                end
            end
            LOAD: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    // Shift in from the top so the first pixel ends at bits [PIX_W-1:0]
                    row_buf_d = {pix_data, row_buf_q[RW-1:PIX_W]};
                    if (pix_cnt_q == LAST_PIX) begin
                        pix_cnt_d = '0;
                        addr_d    = row_q;
                        state_d   = WRITE;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 8'd1;
                    end
                end
            end
            WRITE: begin
                ram_we = 1'b1;
                if (row_q == LAST_ROW) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + 8'd1;
                    state_d = LOAD;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                conv_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign ram_addr  = addr_q;
    assign ram_wdata = row_buf_q;
    assign conv_run  = conv_q;

endmodule

// File: tb/tb_image_row_loader.sv
// Directed bench for image_row_loader: full frames, stalls, ignored
// start, mid-frame reset and back-to-back reload.
module tb_image_row_loader;

    localparam int PIX_W   = 8;
    localparam int ROW_PIX = 130;
    localparam int ROWS    = 130;
    localparam int RW      = PIX_W * ROW_PIX;

    logic          clk;
    logic          reset;
    logic          start;
    logic          pix_valid;
    logic [7:0]    pix_data;
    logic          pix_ready;
    logic          ram_we;
    logic [7:0]    ram_addr;
    logic [RW-1:0] ram_wdata;
    logic          conv_run;
    logic          busy;
    logic          frame_done;

    image_row_loader #(
        .PIX_W  (PIX_W),
        .ROW_PIX(ROW_PIX),
        .ROWS   (ROWS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .conv_run  (conv_run),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int r_s, c_s, wr_n, nacc, dones, k;
    logic [7:0] b0 [ROWS];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge: score whatever the DUT shows for this cycle.
    task automatic observe(input int off);
        int bad;
        if (ram_we) begin
            check("wr_addr", ram_addr, wr_n);
            check("we_with_ready", pix_ready, 0);
            check("row_pix_count", nacc, ROW_PIX);
            bad = 0;
            for (int i = 0; i < ROW_PIX; i++)
                if (ram_wdata[8*i +: 8] !== 8'(wr_n + i + off))
                    bad++;
            check("row_data_bad_bytes", bad, 0);
            if (int'(ram_addr) < ROWS)
                b0[ram_addr] = ram_wdata[7:0];
            wr_n++;
            nacc = 0;
        end
        if (frame_done)
            dones++;
    endtask

    // Drive the next cycle's inputs, note any handshake, advance one clock.
    task automatic drive(input int off, input int gap, input bit glitch);
        pix_valid = (gap == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap);
        pix_data  = 8'(r_s + c_s + off);
        start     = glitch && (r_s == 50) && (c_s < 20);
        if (pix_valid && pix_ready) begin
            nacc++;
            c_s++;
            if (c_s == ROW_PIX) begin
                c_s = 0;
                r_s++;
            end
        end
        @(negedge clk);
        k++;
    endtask

    task automatic begin_frame();
        r_s = 0; c_s = 0; wr_n = 0; nacc = 0; dones = 0; k = 0;
        start     = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 8'hAA;
        @(negedge clk);
        start = 1'b0;
        check("conv_run_drop", conv_run, 0);
        check("busy_on_start", busy, 1);
        check("ready_in_load", pix_ready, 1);
    endtask

    task automatic run_frame(input int off, input int gap, input bit glitch,
                             input bit chk_time);
        begin_frame();
        while (dones == 0 && k < 60000) begin
            observe(off);
            if (dones != 0) begin
                if (chk_time)
                    check("done_cycle", k, 17030);
            end else begin
                drive(off, gap, glitch);
            end
        end
        check("frame_done_seen", dones, 1);
        start     = 1'b0;
        pix_valid = 1'b1;
        @(negedge clk);
        observe(off);
        check("writes_per_frame", wr_n, ROWS);
        check("single_done", dones, 1);
        check("done_pulse_width", frame_done, 0);
        check("conv_run_set", conv_run, 1);
        check("busy_idle", busy, 0);
        check("ready_idle", pix_ready, 0);
    endtask

    initial begin
        int stale;
        reset     = 1'b0;
        start     = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 8'h55;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", pix_ready, 0);
        check("rst_we", ram_we, 0);
        check("rst_conv", conv_run, 0);
        check("rst_done", frame_done, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_wdata_nz", |ram_wdata, 0);
        start     = 1'b0;
        pix_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Continuous stream, valid held in IDLE/WRITE, stray start at row 50
        run_frame(0, 0, 1'b1, 1'b1);
        // Back-to-back reload with ~50% valid gaps
        run_frame(0, 50, 1'b0, 1'b0);

        // Abandon a frame after pixel 70 of row 3
        begin_frame();
        while (!(r_s == 3 && c_s == 71) && k < 2000) begin
            observe(0);
            drive(0, 0, 1'b0);
        end
        observe(0);
        reset     = 1'b0;
        start     = 1'b1;
        pix_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_we", ram_we, 0);
        check("mid_rst_writes", wr_n, 3);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", pix_ready, 0);
        check("mid_rst_conv", conv_run, 0);
        check("mid_rst_done", frame_done, 0);
        check("mid_rst_addr", ram_addr, 0);
        check("mid_rst_wdata_nz", |ram_wdata, 0);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_conv", conv_run, 0);

        // Fresh load with new data must overwrite every row
        run_frame(7, 0, 1'b0, 1'b1);
        stale = 0;
        for (int a = 0; a < ROWS; a++)
            if (b0[a] !== 8'(a + 7))
                stale++;
        check("ram_overwrite_stale", stale, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
